// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings plus
// the shift-direction constants.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_MUL   = 3'b010,
        OP_SHIFT = 3'b011,
        OP_OR    = 3'b100,
        OP_NOT   = 3'b101,
        OP_XOR   = 3'b110,
        OP_NAND  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles
// per product. product presents the value after the current step.
module alu_iter_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     upper_sum;

    // Accumulator holds {partial product, unconsumed multiplier bits}; each
    // step conditionally adds the multiplicand to the top half and shifts right.
    always_comb begin
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        product   = {upper_sum, acc_q[WIDTH-1:1]};
        done      = (cnt_q == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            acc_q   <= {{WIDTH{1'b0}}, b};
            mcand_q <= a;
            cnt_q   <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q <= product;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arithmetic ops, iterative
// multiplier and one-bit-per-cycle shifter behind an IDLE/BUSY/DONE FSM.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             shift_dir,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state_q;
    op_t                op_q;
    logic               dir_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               cout_q;
    logic               zero_q;

    op_t                op_in;
    logic [SHW-1:0]     amt;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum_d;
    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_cout_d;
    logic [WIDTH-1:0]   shift_d;

    assign op_in     = op_t'(op);
    assign amt       = b[SHW-1:0];
    assign mul_start = (state_q == ST_IDLE) && in_valid && (op_in == OP_MUL);

    alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        sum_d      = '0;
        alu_res_d  = a;
        alu_cout_d = 1'b0;
        case (op_in)
            OP_ADD: begin
                sum_d      = {1'b0, a} + {1'b0, b};
                alu_res_d  = sum_d[WIDTH-1:0];
                alu_cout_d = sum_d[WIDTH];
            end
            OP_SUB: begin
                // Carry out of a + ~b + 1 is the "no borrow" flag.
                sum_d      = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                alu_res_d  = sum_d[WIDTH-1:0];
                alu_cout_d = sum_d[WIDTH];
            end
            OP_OR:   alu_res_d = a | b;
            OP_NOT:  alu_res_d = ~a;
            OP_XOR:  alu_res_d = a ^ b;
            OP_NAND: alu_res_d = ~(a & b);
            default: alu_res_d = a;
        endcase
    end

    assign shift_d = (dir_q == SHIFT_RIGHT) ? (result_q >> 1) : (result_q << 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            dir_q       <= SHIFT_LEFT;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q        <= op_in;
                        dir_q       <= shift_dir;
                        result_hi_q <= '0;
                        if (op_in == OP_MUL) begin
                            cout_q  <= 1'b0;
                            zero_q  <= 1'b0;
                            state_q <= ST_BUSY;
                        end else if (op_in == OP_SHIFT && amt != '0) begin
                            // result_q doubles as the shifter's working register.
                            result_q <= a;
                            cnt_q    <= amt;
                            cout_q   <= 1'b0;
                            zero_q   <= 1'b0;
                            state_q  <= ST_BUSY;
                        end else begin
                            result_q <= alu_res_d;
                            cout_q   <= alu_cout_d;
                            zero_q   <= (alu_res_d == '0);
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (op_q == OP_MUL) begin
                        if (mul_done) begin
                            result_q    <= mul_product[WIDTH-1:0];
                            result_hi_q <= mul_product[2*WIDTH-1:WIDTH];
                            cout_q      <= (mul_product[2*WIDTH-1:WIDTH] != '0);
                            zero_q      <= (mul_product[WIDTH-1:0] == '0);
                            state_q     <= ST_DONE;
                        end
                    end else begin
                        result_q <= shift_d;
                        cnt_q    <= cnt_q - SHW'(1);
                        if (cnt_q == SHW'(1)) begin
                            zero_q  <= (shift_d == '0);
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: directed scenarios plus random
// transactions, checked every cycle against an arithmetic reference model.
module tb_alu_seq;

    localparam int W   = 8;
    localparam int SHW = 3;

    localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_MUL = 3'd2, C_SHF = 3'd3;
    localparam logic [2:0] C_OR  = 3'd4, C_NOT = 3'd5, C_XOR = 3'd6, C_NAND = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic         shift_dir = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         cout;
    logic         zero;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int reset_mark = -1;
    int el;
    bit pending = 1'b0;
    bit started = 1'b0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         cout;
        logic         zero;
        int           lat;
    } exp_t;

    exp_t exp_q;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .shift_dir (shift_dir),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .cout      (cout),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain arithmetic on the operands, latency from the op rules.
    function automatic exp_t model(input logic [2:0] o, input logic d,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int n;
        logic [63:0] p;
        e.res  = '0;
        e.hi   = '0;
        e.cout = 1'b0;
        e.lat  = 1;
        n = int'(y[SHW-1:0]);
        p = '0;
        case (o)
            C_ADD: begin
                p = 64'(x) + 64'(y);
                e.res  = p[W-1:0];
                e.cout = p[W];
            end
            C_SUB: begin
                e.res  = x - y;
                e.cout = (x >= y);
            end
            C_MUL: begin
                p = 64'(x) * 64'(y);
                e.res  = p[W-1:0];
                e.hi   = p[2*W-1:W];
                e.cout = (e.hi != '0);
                e.lat  = 1 + W;
            end
            C_SHF: begin
                e.res = d ? (x >> n) : (x << n);
                e.lat = 1 + n;
            end
            C_OR:   e.res = x | y;
            C_NOT:  e.res = ~x;
            C_XOR:  e.res = x ^ y;
            default: e.res = ~(x & y);
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Compare process: on every falling edge the outputs are judged against
    // the model's expectation for the transaction in flight (or idle/reset).
    always @(negedge clk) begin
        if (started && rst_n) begin
            if (cyc == reset_mark) begin
                chk("reset_out_valid", 64'(out_valid), 64'd0);
                chk("reset_in_ready",  64'(in_ready),  64'd1);
                chk("reset_result",    64'(result),    64'd0);
                chk("reset_result_hi", 64'(result_hi), 64'd0);
                chk("reset_cout",      64'(cout),      64'd0);
                chk("reset_zero",      64'(zero),      64'd0);
            end else if (pending) begin
                el = cyc - acc_cyc;
                if (el < exp_q.lat - 1) begin
                    chk("busy_out_valid", 64'(out_valid), 64'd0);
                    chk("busy_in_ready",  64'(in_ready),  64'd0);
                end else begin
                    chk("done_out_valid", 64'(out_valid), 64'd1);
                    chk("done_in_ready",  64'(in_ready),  64'd0);
                    chk("result",         64'(result),    64'(exp_q.res));
                    chk("result_hi",      64'(result_hi), 64'(exp_q.hi));
                    chk("cout",           64'(cout),      64'(exp_q.cout));
                    chk("zero",           64'(zero),      64'(exp_q.zero));
                end
            end else begin
                chk("idle_out_valid", 64'(out_valid), 64'd0);
                chk("idle_in_ready",  64'(in_ready),  64'd1);
            end
        end
    end

    task automatic accept(input logic [2:0] o, input logic d,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) timeout_fail("in_ready_wait");
        op = o; shift_dir = d; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q   = model(o, d, x, y);
        acc_cyc = cyc;
        pending = 1'b1;
    endtask

    task automatic txn(input logic [2:0] o, input logic d,
                       input logic [W-1:0] x, input logic [W-1:0] y, input int stall,
                       input bit lit, input logic [W-1:0] lit_res, input logic [W-1:0] lit_hi,
                       input logic lit_cout, input int lit_lat);
        int n;
        accept(o, d, x, y);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) timeout_fail("out_valid_wait");
        if (lit) begin
            chk("model_res",   64'(exp_q.res),  64'(lit_res));
            chk("model_hi",    64'(exp_q.hi),   64'(lit_hi));
            chk("lit_result",  64'(result),     64'(lit_res));
            chk("lit_hi",      64'(result_hi),  64'(lit_hi));
            chk("lit_cout",    64'(cout),       64'(lit_cout));
            chk("lit_latency", 64'(cyc - acc_cyc + 1), 64'(lit_lat));
        end
        $display("txn op=%0d dir=%0d a=%02h b=%02h -> result=%02h hi=%02h cout=%0d zero=%0d",
                 o, d, x, y, result, result_hi, cout, zero);
        // Back-pressure window: stray in_valid pulses must be ignored.
        repeat (stall) begin
            in_valid = 1'($urandom_range(0, 1));
            op = 3'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        pending   = 1'b0;
    endtask

    task automatic reset_mid(input logic [2:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input int k);
        accept(o, 1'b0, x, y);
        repeat (k) begin
            @(posedge clk); #1;
        end
        $display("txn op=%0d a=%02h b=%02h interrupted by reset after %0d cycles", o, x, y, k);
        rst_n   = 1'b0;
        pending = 1'b0;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        reset_mark = cyc;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        reset_mark = cyc;
        started    = 1'b1;

        txn(C_ADD,  1'b0, 8'hFF, 8'h01, 0, 1'b1, 8'h00, 8'h00, 1'b1, 1);
        txn(C_SUB,  1'b0, 8'h05, 8'h07, 0, 1'b1, 8'hFE, 8'h00, 1'b0, 1);
        txn(C_SUB,  1'b0, 8'h07, 8'h07, 1, 1'b1, 8'h00, 8'h00, 1'b1, 1);
        txn(C_MUL,  1'b0, 8'd200, 8'd3, 0, 1'b1, 8'h58, 8'h02, 1'b1, 9);
        txn(C_MUL,  1'b0, 8'hFF, 8'hFF, 2, 1'b1, 8'h01, 8'hFE, 1'b1, 9);
        txn(C_SHF,  1'b0, 8'h81, 8'd3,  0, 1'b1, 8'h08, 8'h00, 1'b0, 4);
        txn(C_SHF,  1'b1, 8'h81, 8'd7,  0, 1'b1, 8'h01, 8'h00, 1'b0, 8);
        txn(C_SHF,  1'b0, 8'h81, 8'd0,  0, 1'b1, 8'h81, 8'h00, 1'b0, 1);
        txn(C_NAND, 1'b0, 8'hF0, 8'h3C, 5, 1'b1, 8'hCF, 8'h00, 1'b0, 1);

        reset_mid(C_MUL, 8'd200, 8'd3, 4);
        txn(C_OR,   1'b0, 8'h0F, 8'hA0, 0, 1'b1, 8'hAF, 8'h00, 1'b0, 1);
        reset_mid(C_XOR, 8'h55, 8'hAA, 3);
        txn(C_NOT,  1'b0, 8'h3C, 8'h00, 0, 1'b1, 8'hC3, 8'h00, 1'b0, 1);

        for (int i = 0; i < 60; i++) begin
            txn(3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 3), 1'b0, 8'h00, 8'h00, 1'b0, 0);
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
